// File: rtl/pb_job_engine_if.sv
// rtl/pb_job_engine_if.sv - job register port and byte-wide memory port of one packet builder
interface pb_job_engine_if #(
    parameter int AW = 32
);
    logic          start;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_out;
    logic [3:0]    byte_cnt;
    logic [3:0]    pkt_type;
    logic          crc_en;
    logic          ins_crc_err;
    logic          busy;
    logic          irq;
    logic [7:0]    crc_val;

    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [7:0]    rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ack;

    modport slave (
        input  start, addr_in, addr_out, byte_cnt, pkt_type, crc_en, ins_crc_err,
        output busy, irq, crc_val,
        output rd_req, rd_addr,
        input  rd_ack, rd_data,
        output wr_req, wr_addr, wr_data,
        input  wr_ack
    );

    modport master (
        output start, addr_in, addr_out, byte_cnt, pkt_type, crc_en, ins_crc_err,
        input  busy, irq, crc_val,
        input  rd_req, rd_addr,
        output rd_ack, rd_data,
        input  wr_req, wr_addr, wr_data,
        output wr_ack
    );
endinterface

// File: rtl/pb_job_engine.sv
// rtl/pb_job_engine.sv - packet builder job engine: header, copied data bytes, optional CRC8
module pb_job_engine #(
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              reset,
    pb_job_engine_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, HDR, RD, WR, CRC, DONE} state_t;

    state_t        st;
    logic [AW-1:0] j_ain;
    logic [AW-1:0] j_aout;
    logic [3:0]    j_cnt;
    logic [3:0]    j_type;
    logic          j_crc_en;
    logic          j_err;
    logic [3:0]    idx;
    logic [7:0]    crc;
    logic [7:0]    dbuf;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    // Every memory beat follows the same pattern: raise req on the first cycle in the
    // state, then drop it and move on in the cycle the ack arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            j_ain       <= '0;
            j_aout      <= '0;
            j_cnt       <= '0;
            j_type      <= '0;
            j_crc_en    <= 1'b0;
            j_err       <= 1'b0;
            idx         <= '0;
            crc         <= '0;
            dbuf        <= '0;
            bus.busy    <= 1'b0;
            bus.irq     <= 1'b0;
            bus.crc_val <= '0;
            bus.rd_req  <= 1'b0;
            bus.rd_addr <= '0;
            bus.wr_req  <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            case (st)
                IDLE: begin
                    bus.irq <= 1'b0;
                    if (bus.start) begin
                        j_ain    <= bus.addr_in;
                        j_aout   <= bus.addr_out;
                        j_cnt    <= bus.byte_cnt;
                        j_type   <= bus.pkt_type;
                        j_crc_en <= bus.crc_en;
                        j_err    <= bus.ins_crc_err;
                        bus.busy <= 1'b1;
                        st       <= HDR;
                    end
                end
                HDR: begin
                    if (!bus.wr_req) begin
                        bus.wr_req  <= 1'b1;
                        bus.wr_addr <= j_aout;
                        bus.wr_data <= {j_type, j_cnt};
                    end else if (bus.wr_ack) begin
                        bus.wr_req <= 1'b0;
                        crc        <= crc8_step(8'h00, {j_type, j_cnt});
                        idx        <= '0;
                        st         <= RD;
                    end
                end
                RD: begin
                    if (!bus.rd_req) begin
                        bus.rd_req  <= 1'b1;
                        bus.rd_addr <= j_ain + AW'(idx);
                    end else if (bus.rd_ack) begin
                        bus.rd_req <= 1'b0;
                        dbuf       <= bus.rd_data;
                        crc        <= crc8_step(crc, bus.rd_data);
                        st         <= WR;
                    end
                end
                WR: begin
                    if (!bus.wr_req) begin
                        bus.wr_req  <= 1'b1;
                        bus.wr_addr <= j_aout + AW'(idx) + AW'(1);
                        bus.wr_data <= dbuf;
                    end else if (bus.wr_ack) begin
                        bus.wr_req <= 1'b0;
                        if (idx != j_cnt) begin
                            idx <= idx + 4'd1;
                            st  <= RD;
                        end else if (j_crc_en) begin
                            st <= CRC;
                        end else begin
                            bus.irq  <= 1'b1;
                            bus.busy <= 1'b0;
                            st       <= DONE;
                        end
                    end
                end
                CRC: begin
                    if (!bus.wr_req) begin
                        bus.wr_req  <= 1'b1;
                        bus.wr_addr <= j_aout + AW'(j_cnt) + AW'(2);
                        bus.wr_data <= crc ^ {7'b0, j_err};
                    end else if (bus.wr_ack) begin
                        bus.wr_req  <= 1'b0;
                        bus.crc_val <= bus.wr_data;
                        bus.irq     <= 1'b1;
                        bus.busy    <= 1'b0;
                        st          <= DONE;
                    end
                end
                DONE: begin
                    bus.irq <= 1'b0;
                    st      <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pb_job_engine.sv
// tb/tb_pb_job_engine.sv - directed self-checking bench for pb_job_engine
module tb_pb_job_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pb_job_engine_if #(.AW(32)) bus();
    pb_job_engine #(.AW(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int failures = 0;
    int irq_cnt = 0;
    int both_cnt = 0;
    int max_delay = 0;
    bit stall_wr = 1'b0;
    bit job_to;
    logic busy_after;
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] wa_q[$];
    logic [31:0] ra_q[$];
    logic [7:0]  wd_q[$];

    function automatic logic [7:0] crc_add(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    always @(negedge clk) if (bus.irq === 1'b1) irq_cnt++;

    // Memory model: acks after a random 0..max_delay cycle wait, logs every accepted beat.
    initial begin
        int waitc;
        int dly;
        bit have;
        waitc = 0; dly = 0; have = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_ack = 1'b0;
            bus.wr_ack = 1'b0;
            if (reset || (bus.rd_req !== 1'b1 && bus.wr_req !== 1'b1)) begin
                have = 1'b0;
            end else begin
                if (bus.rd_req === 1'b1 && bus.wr_req === 1'b1) both_cnt++;
                if (!have) begin
                    dly   = $urandom_range(0, max_delay);
                    waitc = 0;
                    have  = 1'b1;
                end
                if (bus.wr_req === 1'b1 && stall_wr) begin
                    waitc = 0;
                end else if (waitc >= dly) begin
                    have = 1'b0;
                    if (bus.rd_req === 1'b1) begin
                        bus.rd_data = mem.exists(bus.rd_addr) ? mem[bus.rd_addr] : 8'h00;
                        bus.rd_ack  = 1'b1;
                        ra_q.push_back(bus.rd_addr);
                    end else begin
                        mem[bus.wr_addr] = bus.wr_data;
                        bus.wr_ack = 1'b1;
                        wa_q.push_back(bus.wr_addr);
                        wd_q.push_back(bus.wr_data);
                    end
                end else begin
                    waitc++;
                end
            end
        end
    end

    task automatic run_job(input logic [31:0] ain, input logic [31:0] aout, input logic [3:0] cnt,
                           input logic [3:0] typ, input logic ce, input logic err);
        wa_q.delete(); wd_q.delete(); ra_q.delete();
        @(negedge clk);
        bus.addr_in = ain; bus.addr_out = aout; bus.byte_cnt = cnt;
        bus.pkt_type = typ; bus.crc_en = ce; bus.ins_crc_err = err;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        busy_after = bus.busy;
        job_to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (bus.irq === 1'b1) begin
                job_to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %h exp 0", bus.busy); end
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %h exp 0", bus.irq); end
        checks++; if (bus.crc_val !== 8'h00) begin failures++; $display("FAIL reset_crc_val got %h exp 00", bus.crc_val); end
        checks++; if (bus.rd_req !== 1'b0 || bus.wr_req !== 1'b0) begin failures++; $display("FAIL reset_req got rd=%h wr=%h exp 0 0", bus.rd_req, bus.wr_req); end
        checks++; if (bus.rd_addr !== 32'h0 || bus.wr_addr !== 32'h0 || bus.wr_data !== 8'h0) begin
            failures++; $display("FAIL reset_bus got ra=%h wa=%h wd=%h exp 0", bus.rd_addr, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic check_basic(input string name, input logic [7:0] exp_crc);
        logic [31:0] ea [3];
        logic [7:0]  ed [3];
        ea[0] = 32'h200; ea[1] = 32'h201; ea[2] = 32'h202;
        ed[0] = 8'h10;   ed[1] = 8'h00;   ed[2] = exp_crc;
        checks++; if (job_to !== 1'b0) begin failures++; $display("FAIL %s_timeout got %h exp 0", name, job_to); end
        checks++; if (wa_q.size() != 3) begin failures++; $display("FAIL %s_wcount got %0d exp 3", name, wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                failures++; $display("FAIL %s_write%0d got %h:%h exp %h:%h", name, i, wa_q[i], wd_q[i], ea[i], ed[i]);
            end
        end
        checks++; if (bus.crc_val !== exp_crc) begin failures++; $display("FAIL %s_crc_val got %h exp %h", name, bus.crc_val, exp_crc); end
    endtask

    task automatic test_basic();
        int irq0;
        mem[32'h100] = 8'h00;
        irq0 = irq_cnt;
        run_job(32'h100, 32'h200, 4'd0, 4'd1, 1'b1, 1'b0);
        checks++; if (busy_after !== 1'b1) begin failures++; $display("FAIL basic_busy_next got %h exp 1", busy_after); end
        check_basic("basic", 8'h57);
        checks++; if (irq_cnt - irq0 != 1) begin failures++; $display("FAIL basic_irq got %0d exp 1", irq_cnt - irq0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got %h exp 0", bus.busy); end
    endtask

    task automatic test_crc_err();
        mem[32'h100] = 8'h00;
        run_job(32'h100, 32'h200, 4'd0, 4'd1, 1'b1, 1'b1);
        check_basic("crc_err", 8'h56);
    endtask

    task automatic test_long_random_delay();
        logic [7:0] src [16];
        int irq0;
        max_delay = 5;
        for (int i = 0; i < 16; i++) begin
            src[i] = 8'($urandom);
            mem[32'h1000 + i] = src[i];
        end
        irq0 = irq_cnt;
        run_job(32'h1000, 32'h2000, 4'd15, 4'hA, 1'b0, 1'b0);
        checks++; if (job_to !== 1'b0) begin failures++; $display("FAIL long_timeout got %h exp 0", job_to); end
        checks++; if (wa_q.size() != 17) begin failures++; $display("FAIL long_wcount got %0d exp 17", wa_q.size()); end
        checks++; if (wa_q.size() > 0 && (wa_q[0] !== 32'h2000 || wd_q[0] !== 8'hAF)) begin
            failures++; $display("FAIL long_header got %h:%h exp 00002000:af", wa_q[0], wd_q[0]);
        end
        for (int i = 0; i < 16 && i + 1 < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i+1] !== 32'h2001 + i || wd_q[i+1] !== src[i]) begin
                failures++; $display("FAIL long_data%0d got %h:%h exp %h:%h", i, wa_q[i+1], wd_q[i+1], 32'h2001 + i, src[i]);
            end
        end
        checks++; if (bus.crc_val !== 8'h56) begin failures++; $display("FAIL long_crc_val_held got %h exp 56", bus.crc_val); end
        checks++; if (irq_cnt - irq0 != 1) begin failures++; $display("FAIL long_irq got %0d exp 1", irq_cnt - irq0); end
        max_delay = 0;
    endtask

    task automatic test_wrap();
        logic [7:0] c;
        logic [31:0] a;
        max_delay = 2;
        // Source and destination overlap, so every byte read back is the header 0x23.
        run_job(32'hFFFF_FFFE, 32'hFFFF_FFFE, 4'd3, 4'd2, 1'b1, 1'b0);
        c = 8'h00;
        for (int i = 0; i < 5; i++) c = crc_add(c, 8'h23);
        checks++; if (job_to !== 1'b0) begin failures++; $display("FAIL wrap_timeout got %h exp 0", job_to); end
        checks++; if (ra_q.size() != 4 || wa_q.size() != 6) begin
            failures++; $display("FAIL wrap_counts got rd=%0d wr=%0d exp 4 6", ra_q.size(), wa_q.size());
        end
        for (int i = 0; i < 4 && i < ra_q.size(); i++) begin
            a = 32'hFFFF_FFFE + i;
            checks++; if (ra_q[i] !== a) begin failures++; $display("FAIL wrap_rd%0d got %h exp %h", i, ra_q[i], a); end
        end
        for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
            a = 32'hFFFF_FFFE + i;
            checks++;
            if (wa_q[i] !== a || wd_q[i] !== ((i == 5) ? c : 8'h23)) begin
                failures++; $display("FAIL wrap_wr%0d got %h:%h exp %h:%h", i, wa_q[i], wd_q[i], a, (i == 5) ? c : 8'h23);
            end
        end
        checks++; if (bus.crc_val !== c) begin failures++; $display("FAIL wrap_crc_val got %h exp %h", bus.crc_val, c); end
        max_delay = 0;
    endtask

    task automatic test_start_spam();
        int irq0;
        bit seen;
        mem[32'h300] = 8'hA5; mem[32'h301] = 8'h5A;
        wa_q.delete(); wd_q.delete(); ra_q.delete();
        irq0 = irq_cnt;
        seen = 1'b0;
        @(negedge clk);
        bus.addr_in = 32'h300; bus.addr_out = 32'h400; bus.byte_cnt = 4'd1;
        bus.pkt_type = 4'd3; bus.crc_en = 1'b0; bus.ins_crc_err = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            bus.byte_cnt = 4'd9;
            bus.addr_out = 32'h900;
            if (bus.irq === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        // start stays high through the DONE cycle, then drops before IDLE samples it.
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL spam_timeout got %h exp 1", seen); end
        checks++; if (irq_cnt - irq0 != 1) begin failures++; $display("FAIL spam_irq got %0d exp 1", irq_cnt - irq0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL spam_busy got %h exp 0", bus.busy); end
        checks++; if (wa_q.size() != 3 || ra_q.size() != 2) begin
            failures++; $display("FAIL spam_beats got wr=%0d rd=%0d exp 3 2", wa_q.size(), ra_q.size());
        end
        checks++; if (wa_q.size() == 3 && (wd_q[0] !== 8'h31 || wd_q[2] !== 8'h5A || wa_q[2] !== 32'h402)) begin
            failures++; $display("FAIL spam_data got %h %h@%h exp 31 5a@00000402", wd_q[0], wd_q[2], wa_q[2]);
        end
    endtask

    task automatic test_reset_midjob();
        int irq0;
        bit seen;
        irq0 = irq_cnt;
        seen = 1'b0;
        stall_wr = 1'b1;
        @(negedge clk);
        bus.addr_in = 32'h100; bus.addr_out = 32'h200; bus.byte_cnt = 4'd2;
        bus.pkt_type = 4'd1; bus.crc_en = 1'b1; bus.ins_crc_err = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.wr_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL midrst_wr_req_seen got %h exp 1", seen); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.wr_req !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL midrst_async got wr_req=%h busy=%h exp 0 0", bus.wr_req, bus.busy);
        end
        stall_wr = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (irq_cnt != irq0) begin failures++; $display("FAIL midrst_irq got %0d exp %0d", irq_cnt, irq0); end
        checks++; if (bus.crc_val !== 8'h00) begin failures++; $display("FAIL midrst_crc_val got %h exp 00", bus.crc_val); end
        mem[32'h100] = 8'h00;
        run_job(32'h100, 32'h200, 4'd0, 4'd1, 1'b1, 1'b0);
        check_basic("after_rst", 8'h57);
    endtask

    task automatic test_exclusive();
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL req_exclusive got %0d exp 0", both_cnt); end
    endtask

    initial begin
        bus.start = 1'b0; bus.addr_in = '0; bus.addr_out = '0; bus.byte_cnt = '0;
        bus.pkt_type = '0; bus.crc_en = 1'b0; bus.ins_crc_err = 1'b0;
        bus.rd_ack = 1'b0; bus.rd_data = '0; bus.wr_ack = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        test_basic();
        test_crc_err();
        test_long_random_delay();
        test_wrap();
        test_start_spam();
        test_reset_midjob();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
